// File: rtl/bram_dp_clr.sv
// Dual-port byte-writable RAM (port A read/write, port B read) with a one-word-per-cycle clear engine.
// Define BRAM_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module bram_dp_clr #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 11,
    parameter int ADDR_W = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    output logic                  busy_o,
    input  logic                  ena_i,
    input  logic [DATA_W/8-1:0]   wea_i,
    input  logic [ADDR_W-1:0]     aa_i,
    input  logic [DATA_W-1:0]     dia_i,
    output logic [DATA_W-1:0]     doa_o,
    output logic                  vlda_o,
    input  logic                  enb_i,
    input  logic [ADDR_W-1:0]     ab_i,
    output logic [DATA_W-1:0]     dob_o,
    output logic                  vldb_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = ADDR_W - OFF;
    localparam int CNT_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    idx_a, idx_b;
    logic [CNT_W-1:0]    wa, wb;
    logic                in_a, in_b, blocked, a_wr;
    logic [DATA_W-1:0]   a_word;
    logic [DATA_W-1:0]   doa_q, doa_d, dob_q, dob_d;
    logic                vlda_q, vlda_d, vldb_q, vldb_d;
    logic                unused_lsb;

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A CLR seen in either state (re)starts the sweep from word 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (clr_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o     = (state_q == CLEAR);
    assign blocked    = busy_o | clr_i;
    assign unused_lsb = ^{aa_i[OFF-1:0], ab_i[OFF-1:0]};

    assign idx_a  = aa_i[ADDR_W-1:OFF];
    assign idx_b  = ab_i[ADDR_W-1:OFF];
    assign in_a   = (idx_a < DEPTH_IDX);
    assign in_b   = (idx_b < DEPTH_IDX);
    assign wa     = idx_a[CNT_W-1:0];
    assign wb     = idx_b[CNT_W-1:0];
    assign a_word = byte_merge(mem[wa], dia_i, wea_i);
    assign a_wr   = ena_i & ~blocked & in_a & (|wea_i);

    // The clear sweep and port A writes never overlap: A writes are blocked while busy.
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (a_wr) begin
            mem[wa] <= a_word;
        end
    end

    always_comb begin
        doa_d  = '0;
        vlda_d = 1'b0;
        dob_d  = '0;
        vldb_d = 1'b0;
        if (ena_i && !blocked) begin
            vlda_d = 1'b1;
            if (in_a) doa_d = a_word;
        end
        if (enb_i && !blocked) begin
            vldb_d = 1'b1;
            if (in_b) dob_d = (a_wr && (wb == wa)) ? a_word : mem[wb];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            doa_q  <= '0;
            vlda_q <= 1'b0;
            dob_q  <= '0;
            vldb_q <= 1'b0;
        end else begin
            doa_q  <= doa_d;
            vlda_q <= vlda_d;
            dob_q  <= dob_d;
            vldb_q <= vldb_d;
        end
    end

`ifdef BRAM_OUTREG_EN
    logic [DATA_W-1:0] doa_r_q, dob_r_q;
    logic              vlda_r_q, vldb_r_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            doa_r_q  <= '0;
            vlda_r_q <= 1'b0;
            dob_r_q  <= '0;
            vldb_r_q <= 1'b0;
        end else begin
            doa_r_q  <= doa_q;
            vlda_r_q <= vlda_q;
            dob_r_q  <= dob_q;
            vldb_r_q <= vldb_q;
        end
    end

    assign doa_o  = doa_r_q;
    assign vlda_o = vlda_r_q;
    assign dob_o  = dob_r_q;
    assign vldb_o = vldb_r_q;
`else
    assign doa_o  = doa_q;
    assign vlda_o = vlda_q;
    assign dob_o  = dob_q;
    assign vldb_o = vldb_q;
`endif

endmodule

// File: tb/tb_bram_dp_clr.sv
// Randomized + directed bench for bram_dp_clr against a word-array reference model.
module tb_bram_dp_clr;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 11;
    localparam int ADDR_W = 12;
`ifdef BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic              busy;
    logic              ena = 1'b0;
    logic [3:0]        wea = '0;
    logic [ADDR_W-1:0] aa  = '0;
    logic [31:0]       dia = '0;
    logic [31:0]       doa;
    logic              vlda;
    logic              enb = 1'b0;
    logic [ADDR_W-1:0] ab  = '0;
    logic [31:0]       dob;
    logic              vldb;

    int n_tests = 0;
    int n_fail  = 0;

    bram_dp_clr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .busy_o(busy),
        .ena_i(ena), .wea_i(wea), .aa_i(aa), .dia_i(dia), .doa_o(doa), .vlda_o(vlda),
        .enb_i(enb), .ab_i(ab), .dob_o(dob), .vldb_o(vldb)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: word array, remaining-busy-cycle count, and a latency pipe on the outputs.
    logic [31:0] mdl [DEPTH];
    int          busy_left = DEPTH;
    logic [31:0] e_doa [LAT];
    logic [31:0] e_dob [LAT];
    logic        e_vla [LAT];
    logic        e_vlb [LAT];

    always begin
        @(posedge clk);
        if (rst) begin
            busy_left = DEPTH;
            for (int s = 0; s < LAT; s++) begin
                e_doa[s] = '0; e_dob[s] = '0; e_vla[s] = 1'b0; e_vlb[s] = 1'b0;
            end
        end else begin
            automatic bit blk = (busy_left > 0) || clr;
            automatic int ia  = int'(aa >> 2);
            automatic int ib  = int'(ab >> 2);
            for (int s = LAT - 1; s > 0; s--) begin
                e_doa[s] = e_doa[s-1]; e_dob[s] = e_dob[s-1];
                e_vla[s] = e_vla[s-1]; e_vlb[s] = e_vlb[s-1];
            end
            e_doa[0] = '0; e_dob[0] = '0; e_vla[0] = 1'b0; e_vlb[0] = 1'b0;
            if (!blk && ena) begin
                e_vla[0] = 1'b1;
                if (ia < DEPTH) begin
                    for (int b = 0; b < 4; b++)
                        if (wea[b]) mdl[ia][8*b +: 8] = dia[8*b +: 8];
                    e_doa[0] = mdl[ia];
                end
            end
            if (!blk && enb) begin
                e_vlb[0] = 1'b1;
                if (ib < DEPTH) e_dob[0] = mdl[ib];
            end
            if (clr) begin
                busy_left = DEPTH;
                for (int w = 0; w < DEPTH; w++) mdl[w] = '0;
            end else if (busy_left > 0) begin
                busy_left--;
            end
        end
        #1;
        check("busy", {31'd0, busy}, {31'd0, busy_left > 0});
        check("vlda", {31'd0, vlda}, {31'd0, e_vla[LAT-1]});
        check("doa",  doa,  e_doa[LAT-1]);
        check("vldb", {31'd0, vldb}, {31'd0, e_vlb[LAT-1]});
        check("dob",  dob,  e_dob[LAT-1]);
    end

    task automatic idle_inputs();
        ena = 1'b0; enb = 1'b0; wea = '0; clr = 1'b0;
    endtask

    task automatic write_a(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
        ena = 1'b1; wea = be; aa = a; dia = d; enb = 1'b0;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic read_b(input string nm, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        ena = 1'b0; enb = 1'b1; ab = a;
        @(negedge clk);
        idle_inputs();
        repeat (LAT - 1) @(negedge clk);
        check(nm, dob, exp);
        check({nm, "_vld"}, {31'd0, vldb}, 32'd1);
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int k = 0; k < 60 && busy; k++) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        for (int w = 0; w < DEPTH; w++) mdl[w] = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_doa", doa, 32'd0);
        check("rst_vldb", {31'd0, vldb}, 32'd0);
        rst = 1'b0;
        count_busy(cnt);
        check("busy_after_reset", cnt, 32'd11);
        for (int w = 0; w < DEPTH; w++) read_b("init_zero", ADDR_W'(4 * w), 32'h0);

        write_a(12'h008, 32'hDEADBEEF, 4'hF);
        write_a(12'h008, 32'h00001234, 4'h3);
        read_b("byte_merge", 12'h008, 32'hDEAD1234);

        ena = 1'b1; wea = 4'hF; aa = 12'h010; dia = 32'hCAFEF00D; enb = 1'b1; ab = 12'h010;
        @(negedge clk);
        idle_inputs();
        repeat (LAT - 1) @(negedge clk);
        check("wf_doa", doa, 32'hCAFEF00D);
        check("wf_dob", dob, 32'hCAFEF00D);

        write_a(12'h02C, 32'hFFFFFFFF, 4'hF);
        read_b("oob_read", 12'h02C, 32'h0);
        for (int w = 0; w < DEPTH; w++)
            read_b("oob_nochange", ADDR_W'(4 * w),
                   (w == 2) ? 32'hDEAD1234 : (w == 4) ? 32'hCAFEF00D : 32'h0);

        for (int i = 0; i < 800; i++) begin
            ena = ($urandom_range(0, 9) < 6);
            enb = ($urandom_range(0, 9) < 6);
            wea = 4'($urandom);
            aa  = ADDR_W'($urandom_range(0, 63));
            ab  = ($urandom_range(0, 9) < 3) ? aa : ADDR_W'($urandom_range(0, 63));
            dia = $urandom;
            clr = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        idle_inputs();
        count_busy(cnt);

        for (int w = 0; w < DEPTH; w++) write_a(ADDR_W'(4 * w), 32'h11111111 * (w + 1), 4'hF);
        read_b("fill", 12'h00C, 32'h44444444);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        cnt = 0;
        for (int k = 0; k < 60 && busy; k++) begin
            cnt++;
            clr = (k == 4);
            ena = (k == 2); wea = 4'hF; aa = 12'h000; dia = 32'h5A5A5A5A;
            @(negedge clk);
        end
        idle_inputs();
        check("busy_double_clr", cnt, 32'd16);
        for (int w = 0; w < DEPTH; w++) read_b("cleared", ADDR_W'(4 * w), 32'h0);

        write_a(12'h004, 32'h0BADF00D, 4'hF);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midclr_rst_busy", {31'd0, busy}, 32'd1);
        check("midclr_rst_vlda", {31'd0, vlda}, 32'd0);
        rst = 1'b0;
        count_busy(cnt);
        check("busy_after_midrst", cnt, 32'd11);
        read_b("after_midrst", 12'h004, 32'h0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_dp_clr.md
BRAM_DP_CLR -- requirements
Module: bram_dp_clr

Interface
REQ-001 Parameter DATA_W, 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, 11, number of words.
REQ-003 Parameter ADDR_W, 12, byte-address width; word index = address >> log2(DATA_W/8).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 CLR  in  1  one-cycle request to zero the whole array.
REQ-007 BUSY  out  1  high while the clear engine runs.
REQ-008 ENA  in  1  port A enable (read and/or write).
REQ-009 WEA  in  DATA_W/8  port A byte write enables.
REQ-010 AA  in  ADDR_W  port A byte address.
REQ-011 DiA  in  DATA_W  port A write data.
REQ-012 DoA  out  DATA_W  port A read data.
REQ-013 VLDA  out  1  DoA holds a valid read result.
REQ-014 ENB  in  1  port B read enable.
REQ-015 AB  in  ADDR_W  port B byte address.
REQ-016 DoB  out  DATA_W  port B read data.
REQ-017 VLDB  out  1  DoB holds a valid read result.

Function
REQ-018 Port A write: when ENA=1 and BUSY=0, each byte lane i with WEA[i]=1 SHALL be written at the word index of AA on the clock edge.
REQ-019 Read latency SHALL be 1 cycle: the access sampled at edge N drives DoX/VLDX after edge N until edge N+1.
REQ-020 ENX=0 at edge N SHALL give DoX=0 and VLDX=0 after edge N.
REQ-021 Port A same-address read+write SHALL be write-first; DoA returns the merged new word.
REQ-022 Port B reading the word port A writes on the same edge SHALL return the new word.
REQ-023 Word index >= DEPTH: the write SHALL be dropped, and the read SHALL return DoX=0 with VLDX=1.
REQ-024 Clear engine FSM states: IDLE and CLEAR. In CLEAR, a word counter SHALL start at 0 and write all-zero to one word per cycle through DEPTH-1, then go to IDLE.
REQ-025 A clear SHALL take exactly DEPTH cycles. BUSY=1 in every cycle of CLEAR.
REQ-026 IDLE->CLEAR SHALL occur on the edge where CLR=1 is sampled.
REQ-027 CLR=1 sampled during CLEAR SHALL restart the counter at 0.
REQ-028 While BUSY=1, port A writes SHALL be dropped. Reads on both ports SHALL return DoX=0 with VLDX=0.
REQ-029 An access sampled on the same edge as CLR=1 SHALL be treated as a BUSY access per REQ-028.

Reset
REQ-030 While RST=1: FSM=CLEAR, counter=0, BUSY=1, DoA=DoB=0, VLDA=VLDB=0.
REQ-031 After RST deasserts, the engine SHALL complete a full DEPTH-cycle clear before BUSY falls. Array contents are not otherwise reset.
REQ-032 RST asserted mid-clear or mid-access SHALL abort the operation and restart per REQ-030.

Configuration
REQ-033 Macro BRAM_OUTREG_EN defined: DoA/DoB/VLDA/VLDB each pass through one extra output register, giving read latency 2. That register resets to 0 and follows REQ-020/023/028 values one cycle later.
REQ-034 Macro BRAM_OUTREG_EN undefined: read latency SHALL be exactly 1 with no extra register.

Verification
REQ-035 Release RST -> BUSY=1 for exactly 11 cycles, then 0. Reading all 11 words returns 0x00000000 with VLD=1.
REQ-036 Write A=0x008, DiA=0xDEADBEEF, WEA=0xF. Then write WEA=0x3, DiA=0x00001234 -> read B=0x008 returns 0xDEAD1234.
REQ-037 Same edge: ENA=1, WEA=0xF, AA=0x010, DiA=0xCAFEF00D, and ENB=1, AB=0x010 -> DoA=DoB=0xCAFEF00D one cycle later.
REQ-038 Write AA=0x02C (index 11) with 0xFFFFFFFF -> no array word changes. A read at 0x02C returns 0 with VLD=1.
REQ-039 Fill words with nonzero data, pulse CLR, pulse CLR again 5 cycles later -> BUSY high 16 cycles total. A write issued while BUSY is dropped, and all words read 0 afterwards.
REQ-040 Build with BRAM_OUTREG_EN -> the REQ-036 read appears 2 cycles after ENB. Assert RST mid-clear -> BUSY stays high and a full 11-cycle clear follows release.
